upcnt_ctrl_core: RTL and testbench

Parametrised stopwatch control core combining command decode, run/stop/clear state machine and a prescaled up/down counter in one block. It accepts commands from the UART receiver (byte plus done strobe) and from three debounced buttons. It drives the count value and status to the FND display path. It generalises the fixed 14-bit up-only counter with an up/down mode, a configurable maximum count, a configurable tick rate, and wrap and tick indication.

---
 rtl/upcnt_ctrl_core.sv | 167 ++++++++++++++++
 tb/tb_upcnt_ctrl_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/upcnt_ctrl_core.sv
// upcnt_ctrl_core: stopwatch control core.
// Decodes run/clear/mode commands from a UART byte stream and three debounced
// buttons, sequences a STOP/RUN/CLEAR state machine, and drives a prescaled
// up/down counter with wrap indication.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   i_rx_data    received UART byte, qualified by i_rx_done
//   i_rx_done    one-cycle strobe for i_rx_data
//   i_btn_run    debounced run/stop button (level)
//   i_btn_clear  debounced clear button (level)
//   i_btn_mode   debounced direction button (level)
//   o_count      current count value
//   o_run        1 while in RUN
//   o_dir        0 = count up, 1 = count down
//   o_tick       one-cycle pulse on every count step
//   o_wrap       one-cycle pulse when the count wraps
module upcnt_ctrl_core #(
  parameter int unsigned CNT_W    = 14,
  parameter int unsigned MAX_CNT  = 9999,
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  input  logic             i_btn_run,
  input  logic             i_btn_clear,
  input  logic             i_btn_mode,
  output logic [CNT_W-1:0] o_count,
  output logic             o_run,
  output logic             o_dir,
  output logic             o_tick,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] MAX_V      = CNT_W'(MAX_CNT);
  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_CLEAR
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       btn_d1_q, btn_d2_q;   // {mode, clear, run}
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             run_q, run_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [2:0] btn_evt;
  logic       uart_run, uart_clr, uart_mode;
  logic       ev_run, ev_clr, ev_mode;

  // Two-stage edge detect: event fires the cycle after the button rises.
  assign btn_evt = btn_d1_q & ~btn_d2_q;

  assign uart_run  = i_rx_done && ((i_rx_data == 8'h52) || (i_rx_data == 8'h72));
  assign uart_clr  = i_rx_done && ((i_rx_data == 8'h43) || (i_rx_data == 8'h63));
  assign uart_mode = i_rx_done && ((i_rx_data == 8'h4D) || (i_rx_data == 8'h6D));

  // OR-merge: the same command from both sources in one cycle is one event.
  assign ev_run  = btn_evt[0] | uart_run;
  assign ev_clr  = btn_evt[1] | uart_clr;
  assign ev_mode = btn_evt[2] | uart_mode;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    dir_d   = dir_q ^ ev_mode;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    unique case (state_q)
      ST_STOP: begin
        if (ev_clr)      state_d = ST_CLEAR;
        else if (ev_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ev_clr)      state_d = ST_CLEAR;
        else if (ev_run) state_d = ST_STOP;
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase

    // Tick is judged on the current state, so a stop landing on a tick
    // cycle still completes that step.
    if (state_q == ST_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Step uses the direction already in effect; a simultaneous mode
    // toggle only affects later ticks.
    if (tick_d) begin
      if (!dir_q) begin
        if (count_q == MAX_V) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_V;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end

    // Entering CLEAR overrides any step in the same cycle; the preset
    // value follows the post-toggle direction.
    if (state_d == ST_CLEAR && state_q != ST_CLEAR) begin
      count_d = dir_d ? MAX_V : '0;
      presc_d = '0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
    end

    run_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_STOP;
      btn_d1_q <= '0;
      btn_d2_q <= '0;
      presc_q  <= '0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      run_q    <= 1'b0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_d1_q <= {i_btn_mode, i_btn_clear, i_btn_run};
      btn_d2_q <= btn_d1_q;
      presc_q  <= presc_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      run_q    <= run_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign o_count = count_q;
  assign o_run   = run_q;
  assign o_dir   = dir_q;
  assign o_tick  = tick_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_upcnt_ctrl_core.sv
module tb_upcnt_ctrl_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_mode = 1'b0;
  logic [3:0] count;
  logic       run, dir, tick, wrap;

  int tests = 0;
  int fails = 0;

  // reference model state (RUN-only stepping)
  int   cnt_e;
  int   presc_e;
  logic dir_e;

  logic [7:0] ign [3] = '{8'h00, 8'h41, 8'hFF};

  always #5 clk = ~clk;

  upcnt_ctrl_core #(
    .CNT_W   (4),
    .MAX_CNT (9),
    .TICK_DIV(4),
    .DIV_W   (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .i_btn_run  (btn_run),
    .i_btn_clear(btn_clear),
    .i_btn_mode (btn_mode),
    .o_count    (count),
    .o_run      (run),
    .o_dir      (dir),
    .o_tick     (tick),
    .o_wrap     (wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic uart(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  // Steps n cycles while in RUN with no events, checking against the model.
  task automatic run_check(input int n);
    logic tick_e, wrap_e;
    for (int i = 0; i < n; i++) begin
      step();
      tick_e  = (presc_e == 3);
      presc_e = tick_e ? 0 : presc_e + 1;
      wrap_e  = 1'b0;
      if (tick_e) begin
        if (!dir_e) begin
          if (cnt_e == 9) begin cnt_e = 0; wrap_e = 1'b1; end
          else cnt_e = cnt_e + 1;
        end else begin
          if (cnt_e == 0) begin cnt_e = 9; wrap_e = 1'b1; end
          else cnt_e = cnt_e - 1;
        end
      end
      chk("run_tick", tick, tick_e);
      chk("run_wrap", wrap, wrap_e);
      chk("run_count", count, cnt_e);
    end
  endtask

  initial begin
    // ---- reset state
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_count", count, 0);
    chk("rst_run", run, 0);
    chk("rst_dir", dir, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);

    // ---- async reset mid-count at 5
    uart(8'h72);
    chk("r_run", run, 1);
    cnt_e = 0; presc_e = 0; dir_e = 1'b0;
    run_check(20);
    chk("pre_rst_count", count, 5);
    #2 reset = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_run", run, 0);
    chk("async_tick", tick, 0);
    chk("async_dir", dir, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) step();
    chk("idle_count", count, 0);
    chk("idle_run", run, 0);

    // ---- full up cycle 0..9 -> 0 with wrap
    uart(8'h72);
    chk("r2_run", run, 1);
    chk("r2_count", count, 0);
    cnt_e = 0; presc_e = 0; dir_e = 1'b0;
    run_check(40);

    // ---- clear, then held run button gives one event
    uart(8'h63);
    chk("c_run", run, 0);
    chk("c_count", count, 0);
    step();
    chk("c_stop_run", run, 0);
    btn_run = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      chk("hold_run", run, (k >= 2) ? 1 : 0);
    end
    btn_run = 1'b0;
    chk("hold_count", count, 2);
    cnt_e = 2; presc_e = 0; dir_e = 1'b0;
    run_check(5);
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    step();
    chk("pause_run", run, 0);
    chk("pause_count", count, 3);
    chk("pause_tick", tick, 0);
    repeat (3) step();
    chk("hold_pause_count", count, 3);
    chk("hold_pause_tick", tick, 0);
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    step();
    chk("resume_run", run, 1);
    chk("resume_tick0", tick, 0);
    step();
    chk("resume_tick1", tick, 1);
    chk("resume_count", count, 4);
    chk("resume_wrap", wrap, 0);

    // ---- down mode and clear to MAX
    cnt_e = 4; presc_e = 0; dir_e = 1'b0;
    run_check(32);
    chk("at2_count", count, 2);
    uart(8'h6D);
    chk("m_dir", dir, 1);
    chk("m_count", count, 2);
    chk("m_tick", tick, 0);
    presc_e = 1; dir_e = 1'b1;
    run_check(11);
    uart(8'h43);
    chk("C_run", run, 0);
    chk("C_count", count, 9);
    chk("C_tick", tick, 0);
    step();
    chk("C_stop_run", run, 0);
    chk("C_stop_count", count, 9);
    repeat (5) step();
    chk("C_hold_count", count, 9);

    // ---- clear beats run in the same cycle
    uart(8'h6D);
    chk("m2_dir", dir, 0);
    chk("m2_count", count, 9);
    uart(8'h72);
    chk("r3_run", run, 1);
    btn_clear = 1'b1;
    step();
    uart(8'h72);
    chk("cr_run", run, 0);
    chk("cr_count", count, 0);
    btn_clear = 1'b0;
    step();
    chk("cr_stop_run", run, 0);
    chk("cr_stop_count", count, 0);
    repeat (8) step();
    chk("cr_idle_run", run, 0);
    chk("cr_idle_count", count, 0);
    chk("cr_idle_tick", tick, 0);

    // ---- ignored bytes and unqualified data
    for (int i = 0; i < 3; i++) begin
      uart(ign[i]);
      step();
      chk("ign_run", run, 0);
      chk("ign_count", count, 0);
      chk("ign_dir", dir, 0);
    end
    rx_data = 8'h52;
    rx_done = 1'b0;
    step();
    step();
    rx_data = 8'h00;
    chk("nodone_run", run, 0);

    // ---- remaining decode letters
    uart(8'h52);
    chk("R_run", run, 1);
    uart(8'h4D);
    chk("M_dir", dir, 1);
    uart(8'h63);
    chk("c_lower_run", run, 0);
    chk("c_lower_count", count, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
